game_timer: RTL and testbench
=============================

# game_timer

Match countdown timer for the Pong game. Counts down from a parameterised start time to 0:00 in one-second steps. Presents the remaining time as three BCD digits (minutes, seconds-tens, seconds-ones), which feed directly into the seven-segment display decoder. Flags end of match to the game control logic.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per one-second tick; legal range ≥ 2.
- `START_MIN`, 3: start minutes, 0..9.
- `START_SEC`, 0: start seconds, 0..59.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin counting; honoured only in IDLE.
- `pause` in 1: one-cycle request that toggles RUN↔PAUSE; ignored in IDLE and DONE.
- `clear` in 1: one-cycle request to reload the start time and return to IDLE from any state.
- `min` out 4: BCD minutes digit, 0..9.
- `sec1` out 4: BCD seconds-tens digit, 0..5.
- `sec2` out 4: BCD seconds-ones digit, 0..9.
- `running` out 1: high while in RUN.
- `done` out 1: high while in DONE.
- `time_up` out 1: one-cycle pulse on entry to DONE.

## Operation
- Four states: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Reset values:
  - `min` = START_MIN.
  - `sec1` = START_SEC/10.
  - `sec2` = START_SEC%10.
  - `running` = `done` = `time_up` = 0.
  - Prescaler = 0.
- Input priority per cycle: `clear` > `start` > `pause`.
- IDLE:
  - `start` with start time ≠ 0:00 → RUN.
  - `start` with start time = 0:00 → DONE, with `time_up` pulsed.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - The cycle where prescaler = TICK_DIV-1 is the tick; the digits decrement on that edge.
  - `pause` → PAUSE.
- PAUSE:
  - Prescaler and digits are frozen; the partial count is kept.
  - `pause` → RUN, resuming from the held count.
- DONE:
  - Digits hold 0:00.
  - `start` and `pause` are ignored; only `clear` or reset leaves DONE.
- `clear` in any state:
  - Reloads the start digits and sets the prescaler to 0.
  - Goes to IDLE.
  - Takes priority even if it coincides with a tick.
- Decrement rule (BCD, no binary conversion):
  - If `sec2` > 0: `sec2`−1.
  - Else `sec2` = 9, then:
    - If `sec1` > 0: `sec1`−1.
    - Else `sec1` = 5 and `min`−1.
- Terminal tick: when the tick finds 0:01, the digits become 0:00, the state becomes DONE and `time_up` = 1, all on the same edge.
- `pause` coinciding with a tick in RUN: the decrement is applied and the state goes to PAUSE.
- Digit outputs are registered and always valid BCD; no glitches between ticks.

## Timing
- `start` sampled at edge N → `running` = 1 after edge N.
  - First tick occurs TICK_DIV cycles later.
  - The digits change at edge N+TICK_DIV.
- Tick-to-digit latency: the digits update on the tick edge itself; they are visible in the cycle after.
- `time_up` is high for exactly one cycle. `done` rises together with it and stays high.
- Asynchronous reset assertion forces all reset values immediately, mid-count included. Deassertion is synchronised externally.
- Back-to-back `pause` pulses on consecutive cycles: each toggles, giving net zero change.

## Structure
- Shared game package holds:
  - The state encoding (IDLE/RUN/PAUSE/DONE).
  - The BCD digit width constant (4).
  - The default TICK_DIV.
- One sub-module, `tick_prescaler`:
  - Inputs: `en`, synchronous `clr`.
  - Output: one-cycle `tick`.
  - Counter width = $clog2(TICK_DIV).
- The FSM and BCD decrement logic live in `game_timer`.

## Test plan
- TICK_DIV=4, 0:03 start:
  - Reset: outputs read 0,0,3.
  - `start` → digits 0:02, 0:01, 0:00 at 4, 8, 12 cycles after start.
  - `time_up` pulses once, at 12.
  - `done` = 1 thereafter.
- Borrow chain, 1:00 start:
  - One tick → 0:59.
- Pause while running:
  - Pause at 2 cycles into the period, hold 10 cycles, resume.
  - Next decrement 2 cycles after resume.
  - Digits unchanged during the hold.
- Simultaneous events:
  - `clear` coinciding with a tick → IDLE with start digits, no decrement.
  - `pause` coinciding with a tick → decrement applied, then PAUSE.
- 0:00 start:
  - `start` → DONE next edge, `time_up` pulses once.
  - Further `start`/`pause` ignored until `clear`.
- Reset mid-count at 0:37:
  - Async `rst` low → 3:00 immediately, `running` = 0, no `time_up`.

Source files
------------

// File: rtl/game_timer_pkg.sv
// ============================================================================
// Module      : game_timer_pkg
// Description : Shared types, constants and BCD helper for the match timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DIGIT_W          = 4;
    localparam int DEFAULT_TICK_DIV = 50_000_000;

    typedef struct packed {
        logic [DIGIT_W-1:0] min;
        logic [DIGIT_W-1:0] sec1;
        logic [DIGIT_W-1:0] sec2;
    } bcd_time_t;

    // Digit-wise borrow chain; callers never pass 0:00.
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec2 != '0) begin
            r.sec2 = t.sec2 - 1'b1;
        end else begin
            r.sec2 = DIGIT_W'(9);
            if (t.sec1 != '0) begin
                r.sec1 = t.sec1 - 1'b1;
            end else begin
                r.sec1 = DIGIT_W'(5);
                r.min  = t.min - 1'b1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_timer_tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);
    assign tick   = en && at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_timer.sv
// ============================================================================
// Module      : game_timer
// Description : Match countdown timer with BCD digit outputs and end-of-match flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int START_MIN = 3,
    parameter int START_SEC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    output logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] sec1,
    output logic [DIGIT_W-1:0] sec2,
    output logic               running,
    output logic               done,
    output logic               time_up
);

    localparam bcd_time_t START_TIME = '{
        min:  DIGIT_W'(START_MIN),
        sec1: DIGIT_W'(START_SEC / 10),
        sec2: DIGIT_W'(START_SEC % 10)
    };
    localparam bcd_time_t TIME_ONE = '{min: '0, sec1: '0, sec2: DIGIT_W'(1)};
    localparam bit START_IS_ZERO = (START_MIN == 0) && (START_SEC == 0);

    state_e    state_q, state_d;
    bcd_time_t time_q, time_d;
    logic      time_up_q, time_up_d;
    logic      tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .clr  (clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        time_up_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            time_d  = START_TIME;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (START_IS_ZERO) begin
                            state_d   = ST_DONE;
                            time_up_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        time_d = bcd_decrement(time_q);
                        // Reaching 0:00 wins over a coincident pause.
                        if (time_q == TIME_ONE) begin
                            state_d   = ST_DONE;
                            time_up_d = 1'b1;
                        end else if (pause) begin
                            state_d = ST_PAUSE;
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            time_q    <= START_TIME;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            time_up_q <= time_up_d;
        end
    end

    assign min     = time_q.min;
    assign sec1    = time_q.sec1;
    assign sec2    = time_q.sec2;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign time_up = time_up_q;

endmodule

`default_nettype wire

// File: tb/tb_game_timer.sv
// ============================================================================
// Module      : tb_game_timer
// Description : Directed checks of game_timer across four start-time configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic a_start = 0, a_pause = 0, a_clear = 0;
    logic b_start = 0, b_pause = 0, b_clear = 0;
    logic c_start = 0, c_pause = 0, c_clear = 0;
    logic d_start = 0, d_pause = 0, d_clear = 0;

    logic [3:0] a_min, a_s1, a_s2, b_min, b_s1, b_s2;
    logic [3:0] c_min, c_s1, c_s2, d_min, d_s1, d_s2;
    logic a_run, a_done, a_tu, b_run, b_done, b_tu;
    logic c_run, c_done, c_tu, d_run, d_done, d_tu;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_timer #(.TICK_DIV(4), .START_MIN(0), .START_SEC(3)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .pause(a_pause), .clear(a_clear),
        .min(a_min), .sec1(a_s1), .sec2(a_s2), .running(a_run), .done(a_done), .time_up(a_tu));

    game_timer #(.TICK_DIV(4), .START_MIN(1), .START_SEC(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .pause(b_pause), .clear(b_clear),
        .min(b_min), .sec1(b_s1), .sec2(b_s2), .running(b_run), .done(b_done), .time_up(b_tu));

    game_timer #(.TICK_DIV(4), .START_MIN(0), .START_SEC(0)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .pause(c_pause), .clear(c_clear),
        .min(c_min), .sec1(c_s1), .sec2(c_s2), .running(c_run), .done(c_done), .time_up(c_tu));

    game_timer #(.TICK_DIV(4), .START_MIN(3), .START_SEC(0)) dut_d (
        .clk(clk), .rst(rst), .start(d_start), .pause(d_pause), .clear(d_clear),
        .min(d_min), .sec1(d_s1), .sec2(d_s2), .running(d_run), .done(d_done), .time_up(d_tu));

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        chk("rst_a_digits", {a_min, a_s1, a_s2}, 12'h003);
        chk("rst_a_flags", {9'd0, a_run, a_done, a_tu}, 12'h000);
        chk("rst_d_digits", {d_min, d_s1, d_s2}, 12'h300);
        chk("rst_b_digits", {b_min, b_s1, b_s2}, 12'h100);
        #10 rst = 1'b1;
        step(1);

        // A: 0:03 countdown
        a_start = 1; step(1); a_start = 0;
        chk("a_run_after_start", {11'd0, a_run}, 12'h001);
        chk("a_digits_n0", {a_min, a_s1, a_s2}, 12'h003);
        step(3);
        chk("a_digits_n3", {a_min, a_s1, a_s2}, 12'h003);
        step(1);
        chk("a_digits_n4", {a_min, a_s1, a_s2}, 12'h002);
        step(4);
        chk("a_digits_n8", {a_min, a_s1, a_s2}, 12'h001);
        chk("a_tu_n8", {11'd0, a_tu}, 12'h000);
        step(3);
        chk("a_digits_n11", {a_min, a_s1, a_s2}, 12'h001);
        chk("a_done_n11", {11'd0, a_done}, 12'h000);
        step(1);
        chk("a_digits_n12", {a_min, a_s1, a_s2}, 12'h000);
        chk("a_flags_n12", {9'd0, a_run, a_done, a_tu}, 12'h003);
        step(1);
        chk("a_flags_n13", {9'd0, a_run, a_done, a_tu}, 12'h002);
        a_start = 1; a_pause = 1; step(1); a_start = 0; a_pause = 0;
        chk("a_done_ignores", {9'd0, a_run, a_done, a_tu}, 12'h002);
        chk("a_done_digits", {a_min, a_s1, a_s2}, 12'h000);

        // B: 1:00 borrow chain, pause on tick, clear on tick
        b_start = 1; step(1); b_start = 0;
        step(3);
        chk("b_digits_n3", {b_min, b_s1, b_s2}, 12'h100);
        step(1);
        chk("b_borrow", {b_min, b_s1, b_s2}, 12'h059);
        step(3);
        b_pause = 1; step(1); b_pause = 0;
        chk("b_pause_tick_digits", {b_min, b_s1, b_s2}, 12'h058);
        chk("b_pause_tick_run", {11'd0, b_run}, 12'h000);
        step(5);
        chk("b_paused_hold", {b_min, b_s1, b_s2}, 12'h058);
        b_pause = 1; step(1); b_pause = 0;
        chk("b_resumed", {11'd0, b_run}, 12'h001);
        step(2);
        chk("b_pre_clear", {b_min, b_s1, b_s2}, 12'h058);
        step(1);
        b_clear = 1; step(1); b_clear = 0;
        chk("b_clear_tick_digits", {b_min, b_s1, b_s2}, 12'h100);
        chk("b_clear_tick_flags", {9'd0, b_run, b_done, b_tu}, 12'h000);
        step(5);
        chk("b_idle_hold", {b_min, b_s1, b_s2}, 12'h100);

        // C: 0:00 start
        c_start = 1; step(1); c_start = 0;
        chk("c_zero_flags", {9'd0, c_run, c_done, c_tu}, 12'h003);
        chk("c_zero_digits", {c_min, c_s1, c_s2}, 12'h000);
        step(1);
        chk("c_tu_once", {9'd0, c_run, c_done, c_tu}, 12'h002);
        c_start = 1; step(1); c_start = 0;
        c_pause = 1; step(1); c_pause = 0;
        chk("c_ignored", {9'd0, c_run, c_done, c_tu}, 12'h002);
        c_clear = 1; step(1); c_clear = 0;
        chk("c_cleared", {9'd0, c_run, c_done, c_tu}, 12'h000);

        // D: 3:00 pause mid-period, double pause, run to 0:37, async reset
        d_start = 1; step(1); d_start = 0;
        step(1);
        d_pause = 1; step(1); d_pause = 0;
        chk("d_paused_run", {11'd0, d_run}, 12'h000);
        step(5);
        chk("d_hold5", {d_min, d_s1, d_s2}, 12'h300);
        step(5);
        chk("d_hold10", {d_min, d_s1, d_s2}, 12'h300);
        chk("d_hold10_run", {11'd0, d_run}, 12'h000);
        d_pause = 1; step(1); d_pause = 0;
        chk("d_resume_run", {11'd0, d_run}, 12'h001);
        step(1);
        chk("d_resume_plus1", {d_min, d_s1, d_s2}, 12'h300);
        step(1);
        chk("d_resume_plus2", {d_min, d_s1, d_s2}, 12'h259);
        d_pause = 1; step(2); d_pause = 0;
        chk("d_double_pause_run", {11'd0, d_run}, 12'h001);
        step(2);
        chk("d_double_pause_digits", {d_min, d_s1, d_s2}, 12'h259);
        step(1);
        chk("d_after_double", {d_min, d_s1, d_s2}, 12'h258);
        step(564);
        chk("d_at_037", {d_min, d_s1, d_s2}, 12'h037);
        step(2);
        #2 rst = 1'b0;
        #1;
        chk("d_async_rst_digits", {d_min, d_s1, d_s2}, 12'h300);
        chk("d_async_rst_flags", {9'd0, d_run, d_done, d_tu}, 12'h000);
        chk("a_async_rst_flags", {9'd0, a_run, a_done, a_tu}, 12'h000);
        #10 rst = 1'b1;
        step(2);
        chk("d_post_rst_flags", {9'd0, d_run, d_done, d_tu}, 12'h000);
        chk("d_post_rst_digits", {d_min, d_s1, d_s2}, 12'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
